// File: rtl/ams_dac_pkg.sv
// Shared types and defaults for the 1-bit sigma-delta DAC.
package ams_dac_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int PERIOD_W_DEF   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ams_dac_fifo.sv
// Small synchronous FIFO, no write-to-read bypass. Pointers carry one
// extra wrap bit so occupancy is a plain subtraction.
module ams_dac_fifo
  import ams_dac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int LVL_W  = lvl_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LVL_W-1:0]  level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_q, rd_q;
  logic [AW:0]       level;
  logic              do_push, do_pop;

  assign level   = wr_q - rd_q;
  assign full_o  = (level == (AW+1)'(DEPTH));
  assign empty_o = (level == '0);
  assign level_o = LVL_W'(level);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer update; reset empties the queue without touching storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Sample storage.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ams_dac_1b.sv
// First-order sigma-delta PDM DAC fed from a sample FIFO at a
// programmable sample period.
module ams_dac_1b
  import ams_dac_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int PERIOD_W   = PERIOD_W_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic [PERIOD_W-1:0]            period_i,
  input  logic [DATA_W-1:0]              sample_i,
  input  logic                           sample_valid_i,
  output logic                           sample_ready_o,
  output logic [lvl_w(FIFO_DEPTH)-1:0]   level_o,
  input  logic                           underrun_clr_i,
  output logic                           underrun_o,
  output logic                           dac_o
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   cur_q, cur_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                dac_q, dac_d;
  logic                und_q, und_d;
  logic                und_set;
  logic [DATA_W:0]     sum;

  logic                pop, full, empty;
  logic [DATA_W-1:0]   head;

  ams_dac_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (sample_valid_i),
    .data_i  (sample_i),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );

  assign sample_ready_o = !full;
  assign underrun_o     = und_q;
  assign dac_o          = dac_q;
  assign sum            = {1'b0, acc_q} + {1'b0, cur_q};

  // Next-state: IDLE waits for data, RUN modulates and strobes every
  // period_i+1 cycles. Compare uses >= so a shrinking period never stalls.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    dac_d   = dac_q;
    pop     = 1'b0;
    und_set = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        dac_d = 1'b0;
        cnt_d = '0;
        if (en_i && !empty) begin
          pop     = 1'b1;
          cur_d   = head;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en_i) begin
          state_d = IDLE;
          acc_d   = '0;
          dac_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          acc_d = sum[DATA_W-1:0];
          dac_d = sum[DATA_W];
          if (cnt_q >= period_i) begin
            cnt_d = '0;
            if (!empty) begin
              pop   = 1'b1;
              cur_d = head;
            end else begin
              und_set = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh underrun outranks a clear in the same cycle.
    und_d = und_set | (und_q & ~underrun_clr_i);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      dac_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      dac_q   <= dac_d;
      und_q   <= und_d;
    end
  end

endmodule

// File: tb/tb_ams_dac_1b.sv
// Bench for ams_dac_1b: table vectors, directed corner sequences and a
// randomized run, all compared to a queue-based behavioural model.
module tb_ams_dac_1b;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int PERIOD_W   = 16;
  localparam int LW         = 3;

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic                en_i = 1'b0;
  logic [PERIOD_W-1:0] period_i = '0;
  logic [DATA_W-1:0]   sample_i = '0;
  logic                sample_valid_i = 1'b0;
  logic                sample_ready_o;
  logic [LW-1:0]       level_o;
  logic                underrun_clr_i = 1'b0;
  logic                underrun_o;
  logic                dac_o;

  ams_dac_1b #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .PERIOD_W(PERIOD_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .period_i       (period_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .level_o        (level_o),
    .underrun_clr_i (underrun_clr_i),
    .underrun_o     (underrun_o),
    .dac_o          (dac_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model: a queue for the buffer, integers for the modulator.
  int  mq[$];
  bit  m_run;
  int  m_acc, m_cur, m_cnt;
  bit  m_dac, m_und;

  task automatic model_step();
    bit  was_empty, was_full, set;
    int  total;
    was_empty = (mq.size() == 0);
    was_full  = (mq.size() == FIFO_DEPTH);
    set = 0;
    if (rst_i) begin
      mq.delete();
      m_run = 0; m_acc = 0; m_cur = 0; m_cnt = 0; m_dac = 0; m_und = 0;
      return;
    end
    if (!m_run) begin
      m_acc = 0; m_dac = 0; m_cnt = 0;
      if (en_i && !was_empty) begin
        m_cur = mq.pop_front();
        m_run = 1;
      end
    end else if (!en_i) begin
      m_run = 0; m_acc = 0; m_dac = 0; m_cnt = 0;
    end else begin
      total = m_acc + m_cur;
      m_dac = (total >= 256);
      m_acc = total % 256;
      if (m_cnt >= int'(period_i)) begin
        m_cnt = 0;
        if (!was_empty) m_cur = mq.pop_front();
        else set = 1;
      end else begin
        m_cnt++;
      end
    end
    if (set) m_und = 1;
    else if (underrun_clr_i) m_und = 0;
    if (sample_valid_i && !was_full) mq.push_back(int'(sample_i));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("m_dac", dac_o, m_dac);
    chk("m_level", level_o, mq.size());
    chk("m_ready", sample_ready_o, mq.size() < FIFO_DEPTH);
    chk("m_underrun", underrun_o, m_und);
  endtask

  task automatic do_reset();
    rst_i = 1; sample_valid_i = 0; en_i = 0; underrun_clr_i = 0;
    tick();
    rst_i = 0;
  endtask

  task automatic push(input logic [7:0] d);
    sample_valid_i = 1; sample_i = d;
    tick();
    sample_valid_i = 0;
  endtask

  typedef struct {
    logic       valid;
    logic [7:0] sample;
    logic       en;
    int         exp_level;
    logic       exp_ready;
  } vec_t;

  vec_t tbl[6];

  typedef struct {
    logic [7:0] sample;
    int         ones;
  } dens_t;

  dens_t dens[3];

  initial begin
    int ones;

    tbl[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b1};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 2, 1'b1};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 3, 1'b1};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 4, 1'b0};
    tbl[4] = '{1'b1, 8'h55, 1'b0, 4, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 3, 1'b1};
    dens[0] = '{8'h40, 64};
    dens[1] = '{8'h00, 0};
    dens[2] = '{8'hFF, 255};

    // Reset state
    do_reset();
    chk("rst_level", level_o, 0);
    chk("rst_ready", sample_ready_o, 1);
    chk("rst_underrun", underrun_o, 0);
    chk("rst_dac", dac_o, 0);

    // Fill with modulator off, fifth push dropped, then enable pops one
    period_i = 255;
    for (int i = 0; i < 6; i++) begin
      sample_valid_i = tbl[i].valid;
      sample_i       = tbl[i].sample;
      en_i           = tbl[i].en;
      tick();
      chk("tbl_level", level_o, tbl[i].exp_level);
      chk("tbl_ready", sample_ready_o, tbl[i].exp_ready);
    end
    chk("tbl_cur", dut.cur_q, 8'h11);

    // Density over one full accumulator period
    for (int k = 0; k < 3; k++) begin
      do_reset();
      period_i = 255;
      push(dens[k].sample);
      en_i = 1;
      tick();
      ones = 0;
      for (int c = 0; c < 256; c++) begin
        tick();
        ones += int'(dac_o);
      end
      chk("density_ones", ones, dens[k].ones);
    end

    // Underrun sequence at period 3
    do_reset();
    period_i = 3;
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    en_i = 1;
    tick();
    chk("ur_load_level", level_o, 3);
    for (int s = 0; s < 3; s++) begin
      repeat (4) tick();
      chk("ur_pop_level", level_o, 2 - s);
      chk("ur_no_underrun", underrun_o, 0);
    end
    repeat (3) tick();
    chk("ur_before", underrun_o, 0);
    tick();
    chk("ur_set", underrun_o, 1);
    chk("ur_cur_hold", dut.cur_q, 8'h40);
    underrun_clr_i = 1;
    tick();
    underrun_clr_i = 0;
    chk("ur_clr", underrun_o, 0);
    repeat (2) tick();
    underrun_clr_i = 1;
    tick();
    underrun_clr_i = 0;
    chk("ur_set_wins", underrun_o, 1);

    // Reset mid-RUN with three samples queued
    do_reset();
    period_i = 10;
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    en_i = 1;
    repeat (3) tick();
    chk("mr_level_pre", level_o, 3);
    rst_i = 1; sample_valid_i = 1; sample_i = 8'h77;
    tick();
    rst_i = 0; sample_valid_i = 0; en_i = 0;
    chk("mr_level", level_o, 0);
    chk("mr_dac", dac_o, 0);
    chk("mr_ready", sample_ready_o, 1);
    chk("mr_underrun", underrun_o, 0);

    // Period 0 streaming: one pop per cycle, level steady
    do_reset();
    period_i = 0;
    push(8'h01); push(8'h02);
    en_i = 1;
    sample_valid_i = 1;
    for (int c = 0; c < 10; c++) begin
      sample_i = 8'($urandom);
      tick();
      chk("p0_level", level_o, 2);
      chk("p0_underrun", underrun_o, 0);
    end
    sample_valid_i = 0;

    // Enable dropped mid-RUN
    do_reset();
    period_i = 5;
    push(8'h80); push(8'h90);
    en_i = 1;
    repeat (4) tick();
    en_i = 0;
    tick();
    chk("ed_dac", dac_o, 0);
    chk("ed_acc", dut.acc_q, 0);
    chk("ed_cur", dut.cur_q, 8'h80);
    chk("ed_level", level_o, 1);
    en_i = 1;
    tick();
    chk("ed_reload", dut.cur_q, 8'h90);

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      sample_valid_i = ($urandom_range(0, 1) == 1);
      sample_i       = 8'($urandom);
      en_i           = ($urandom_range(0, 9) != 0);
      underrun_clr_i = ($urandom_range(0, 9) == 0);
      rst_i          = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 31) == 0) period_i = PERIOD_W'($urandom_range(0, 6));
      tick();
    end
    rst_i = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
